// File: rtl/dpram_param_if.sv
// Port bundle for dpram_param: two symmetric access ports plus the clear-sweep controls.
// The RAM drives the slave side; whoever issues accesses uses the master side.
interface dpram_param_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 10
);
   logic              a_en;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [WIDTH-1:0]  a_wdata;
   logic [WIDTH-1:0]  a_rdata;

   logic              b_en;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [WIDTH-1:0]  b_wdata;
   logic [WIDTH-1:0]  b_rdata;

   logic              clear_req;
   logic              busy;

   modport master (
      output a_en, a_we, a_addr, a_wdata,
      output b_en, b_we, b_addr, b_wdata,
      output clear_req,
      input  a_rdata, b_rdata, busy
   );

   modport slave (
      input  a_en, a_we, a_addr, a_wdata,
      input  b_en, b_we, b_addr, b_wdata,
      input  clear_req,
      output a_rdata, b_rdata, busy
   );
endinterface

// File: rtl/dpram_param.sv
// Dual-port single-clock RAM with registered reads, selectable own-port write behaviour
// and a full-memory clear sweep that can be requested at run time or started by reset.
module dpram_param #(
   parameter int WIDTH          = 16,
   parameter int DEPTH          = 1024,
   parameter int WRITE_FIRST    = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int ADDR_W        = $clog2(DEPTH)
) (
   input logic          clock,
   input logic          reset,
   dpram_param_if.slave bus
);

   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("dpram_param: WIDTH must be in 1..64");
   end
   if (DEPTH < 2 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dpram_param: DEPTH must be a power of two in 2..65536");
   end

   localparam logic [0:0]        IDLE      = 1'b0;
   localparam logic [0:0]        CLEAR     = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [0:0]        RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [0:0]        state;
   logic              busy_q;
   logic [ADDR_W-1:0] sweep_cnt;
   logic [WIDTH-1:0]  a_rdata_q;
   logic [WIDTH-1:0]  b_rdata_q;

   logic in_idle;
   logic sweep_last;
   logic a_wr;
   logic b_wr;

   assign in_idle    = (state == IDLE);
   assign sweep_last = (sweep_cnt == LAST_ADDR);
   assign a_wr       = in_idle & bus.a_en & bus.a_we;
   assign b_wr       = in_idle & bus.b_en & bus.b_we;

   // Sweep controller; busy is registered alongside state so it always equals "in CLEAR".
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= RST_STATE;
         busy_q    <= (CLEAR_ON_RESET != 0);
         sweep_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.clear_req) begin
                  state     <= CLEAR;
                  busy_q    <= 1'b1;
                  sweep_cnt <= '0;
               end
            end
            CLEAR: begin
               if (sweep_last) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  sweep_cnt <= sweep_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset; port B is written last so it wins a same-address collision.
   always_ff @(posedge clock) begin
      if (state == CLEAR) begin
         mem[sweep_cnt] <= '0;
      end else begin
         if (a_wr) begin
            mem[bus.a_addr] <= bus.a_wdata;
         end
         if (b_wr) begin
            mem[bus.b_addr] <= bus.b_wdata;
         end
      end
   end

   // Reads sample the array before this edge's writes, so the other port always sees old data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else if (state == CLEAR) begin
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         if (bus.a_en) begin
            a_rdata_q <= (bus.a_we && WRITE_FIRST != 0) ? bus.a_wdata : mem[bus.a_addr];
         end
         if (bus.b_en) begin
            b_rdata_q <= (bus.b_we && WRITE_FIRST != 0) ? bus.b_wdata : mem[bus.b_addr];
         end
      end
   end

   assign bus.a_rdata = a_rdata_q;
   assign bus.b_rdata = b_rdata_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: three instances (write-first off/on, clear-on-reset off) driven in
// lockstep and compared every cycle against a word-level memory model.
module tb_dpram_param;
   localparam int WIDTH  = 16;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clock;
   logic              reset;
   logic              a_en, a_we, b_en, b_we, clear_req;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [WIDTH-1:0]  a_wdata, b_wdata;

   dpram_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus0 ();
   dpram_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus1 ();
   dpram_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus2 ();

   assign bus0.a_en = a_en;  assign bus0.a_we = a_we;  assign bus0.a_addr = a_addr;  assign bus0.a_wdata = a_wdata;
   assign bus0.b_en = b_en;  assign bus0.b_we = b_we;  assign bus0.b_addr = b_addr;  assign bus0.b_wdata = b_wdata;
   assign bus0.clear_req = clear_req;
   assign bus1.a_en = a_en;  assign bus1.a_we = a_we;  assign bus1.a_addr = a_addr;  assign bus1.a_wdata = a_wdata;
   assign bus1.b_en = b_en;  assign bus1.b_we = b_we;  assign bus1.b_addr = b_addr;  assign bus1.b_wdata = b_wdata;
   assign bus1.clear_req = clear_req;
   assign bus2.a_en = a_en;  assign bus2.a_we = a_we;  assign bus2.a_addr = a_addr;  assign bus2.a_wdata = a_wdata;
   assign bus2.b_en = b_en;  assign bus2.b_we = b_we;  assign bus2.b_addr = b_addr;  assign bus2.b_wdata = b_wdata;
   assign bus2.clear_req = clear_req;

   dpram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRITE_FIRST(0), .CLEAR_ON_RESET(1))
      dut_wf0 (.clock(clock), .reset(reset), .bus(bus0));
   dpram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRITE_FIRST(1), .CLEAR_ON_RESET(1))
      dut_wf1 (.clock(clock), .reset(reset), .bus(bus1));
   dpram_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRITE_FIRST(0), .CLEAR_ON_RESET(0))
      dut_nocl (.clock(clock), .reset(reset), .bus(bus2));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: memory contents, expected read data per write-first flavour, sweep cycles left.
   logic [WIDTH-1:0] ref_mem [DEPTH];
   logic [WIDTH-1:0] exp_a [2];
   logic [WIDTH-1:0] exp_b [2];
   int               sweep_left;
   int               sweep_left2;
   bit               a2_zero, b2_zero;
   int               checks = 0;
   int               errors = 0;

   task automatic check_output(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic check_all(input string tag);
      check_output({tag, "/wf0.a"}, bus0.a_rdata, exp_a[0]);
      check_output({tag, "/wf0.b"}, bus0.b_rdata, exp_b[0]);
      check_output({tag, "/wf1.a"}, bus1.a_rdata, exp_a[1]);
      check_output({tag, "/wf1.b"}, bus1.b_rdata, exp_b[1]);
      check_output({tag, "/wf0.busy"}, 16'(bus0.busy), 16'(sweep_left > 0));
      check_output({tag, "/wf1.busy"}, 16'(bus1.busy), 16'(sweep_left > 0));
      check_output({tag, "/nocl.busy"}, 16'(bus2.busy), 16'(sweep_left2 > 0));
      if (a2_zero) check_output({tag, "/nocl.a"}, bus2.a_rdata, '0);
      if (b2_zero) check_output({tag, "/nocl.b"}, bus2.b_rdata, '0);
   endtask

   // Advance the model by one clock edge using the inputs that were presented at that edge.
   task automatic model_edge();
      if (sweep_left > 0) begin
         sweep_left--;
         exp_a = '{default: '0};
         exp_b = '{default: '0};
      end else begin
         for (int wf = 0; wf < 2; wf++) begin
            if (a_en) exp_a[wf] = (a_we && wf == 1) ? a_wdata : ref_mem[a_addr];
            if (b_en) exp_b[wf] = (b_we && wf == 1) ? b_wdata : ref_mem[b_addr];
         end
         if (a_en && a_we) ref_mem[a_addr] = a_wdata;
         if (b_en && b_we) ref_mem[b_addr] = b_wdata;
         if (clear_req) begin
            ref_mem    = '{default: '0};
            sweep_left = DEPTH;
         end
      end
      if (sweep_left2 > 0) begin
         sweep_left2--;
         a2_zero = 1'b1;
         b2_zero = 1'b1;
      end else begin
         if (a_en) a2_zero = 1'b0;
         if (b_en) b2_zero = 1'b0;
         if (clear_req) sweep_left2 = DEPTH;
      end
   endtask

   task automatic apply_stimulus(input string tag,
                                 input logic ae, input logic awe, input logic [ADDR_W-1:0] aad,
                                 input logic [WIDTH-1:0] awd,
                                 input logic be, input logic bwe, input logic [ADDR_W-1:0] bad,
                                 input logic [WIDTH-1:0] bwd, input logic cr);
      a_en = ae;  a_we = awe;  a_addr = aad;  a_wdata = awd;
      b_en = be;  b_we = bwe;  b_addr = bad;  b_wdata = bwd;
      clear_req = cr;
      @(posedge clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_step(input string tag);
      apply_stimulus(tag, 0, 0, '0, '0, 0, 0, '0, '0, 0);
   endtask

   // Reset is raised asynchronously between edges and checked before the next edge arrives.
   task automatic do_reset(input string tag);
      a_en = 0;  a_we = 0;  b_en = 0;  b_we = 0;  clear_req = 0;
      #2;
      reset = 1'b1;
      #1;
      ref_mem     = '{default: '0};
      exp_a       = '{default: '0};
      exp_b       = '{default: '0};
      sweep_left  = DEPTH;
      sweep_left2 = 0;
      a2_zero     = 1'b1;
      b2_zero     = 1'b1;
      check_all(tag);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      a_en = 0;  a_we = 0;  a_addr = '0;  a_wdata = '0;
      b_en = 0;  b_we = 0;  b_addr = '0;  b_wdata = '0;
      clear_req = 0;

      do_reset("por");
      for (int i = 0; i < DEPTH; i++) idle_step("por_sweep");

      apply_stimulus("lat_wr", 1, 1, 4'd3, 16'hBEEF, 0, 0, '0, '0, 0);
      apply_stimulus("lat_rd", 0, 0, '0, '0, 1, 0, 4'd3, '0, 0);
      check_output("lat_beef", bus0.b_rdata, 16'hBEEF);
      apply_stimulus("rd5", 1, 0, 4'd5, '0, 0, 0, '0, '0, 0);

      apply_stimulus("coll_wr", 1, 1, 4'd7, 16'h1111, 1, 1, 4'd7, 16'h2222, 0);
      apply_stimulus("coll_rd", 1, 0, 4'd7, '0, 0, 0, '0, '0, 0);
      check_output("coll_2222", bus0.a_rdata, 16'h2222);

      apply_stimulus("xp_pre", 1, 1, 4'd2, 16'h0005, 0, 0, '0, '0, 0);
      apply_stimulus("xp_wr", 1, 1, 4'd2, 16'hAAAA, 1, 0, 4'd2, '0, 0);
      check_output("xp_b_old", bus0.b_rdata, 16'h0005);
      check_output("wf0_old", bus0.a_rdata, 16'h0005);
      check_output("wf1_new", bus1.a_rdata, 16'hAAAA);

      apply_stimulus("hold_wr", 1, 1, 4'd9, 16'h1234, 0, 0, '0, '0, 0);
      apply_stimulus("hold_rd", 1, 0, 4'd9, '0, 1, 0, 4'd9, '0, 0);
      for (int i = 0; i < 5; i++)
         apply_stimulus("hold", 0, 1'($urandom), 4'($urandom), 16'($urandom),
                        0, 1'($urandom), 4'($urandom), 16'($urandom), 0);
      check_output("hold_a", bus0.a_rdata, 16'h1234);
      check_output("hold_b", bus0.b_rdata, 16'h1234);

      for (int i = 0; i < 300; i++) begin
         apply_stimulus("rand",
            1'($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom),
            16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom),
            16'($urandom),
            1'($urandom_range(0, 63) == 0));
      end
      for (int i = 0; i < DEPTH + 2 && (sweep_left > 0 || sweep_left2 > 0); i++) idle_step("drain");

      for (int i = 0; i < DEPTH / 2; i++)
         apply_stimulus("fill", 1, 1, 4'(2 * i), 16'hFFFF, 1, 1, 4'(2 * i + 1), 16'hFFFF, 0);
      apply_stimulus("clr_req", 1, 1, 4'd0, 16'h5555, 1, 0, 4'd1, '0, 1);
      check_output("clr_same_cycle", bus0.b_rdata, 16'hFFFF);
      for (int i = 0; i < DEPTH; i++)
         apply_stimulus("clr_busy", 1, 1, 4'($urandom), 16'($urandom),
                        1, 1, 4'($urandom), 16'($urandom), 0);
      for (int i = 0; i < DEPTH / 2; i++)
         apply_stimulus("clr_rd", 1, 0, 4'(2 * i), '0, 1, 0, 4'(2 * i + 1), '0, 0);

      apply_stimulus("rereq_start", 1, 1, 4'd4, 16'h00C3, 0, 0, '0, '0, 1);
      for (int i = 1; i <= DEPTH; i++)
         apply_stimulus("rereq", 0, 0, '0, '0, 0, 0, '0, '0, (i == 4));
      idle_step("rereq_done");

      for (int i = 0; i < 5; i++)
         apply_stimulus("pre_rst", 1, 1, 4'(i), 16'(16'h0100 + i), 0, 0, '0, '0, 0);
      apply_stimulus("mid_start", 0, 0, '0, '0, 0, 0, '0, '0, 1);
      for (int i = 1; i <= 9; i++) idle_step("mid_sweep");
      do_reset("mid_rst");
      for (int i = 0; i < DEPTH; i++) idle_step("post_rst");
      for (int i = 0; i < 4; i++)
         apply_stimulus("post_rd", 1, 0, 4'(i), '0, 1, 0, 4'(i + 4), '0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
